// File: rtl/aligned_pair_buffer.sv
// aligned_pair_buffer
//   Collects the aligned symbol pairs that the Needleman-Wunsch traceback
//   emits end-to-start and replays them start-to-end over a valid/ready
//   stream. The buffer can be replayed any number of times until it is
//   cleared or reset.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   clear                 synchronous restart (same effect as reset)
//   wr_en/wr_sym_a/_b     one traceback pair per cycle while filling
//   wr_last               traceback finished; may coincide with wr_en
//   len, full             number of stored pairs, len == DEPTH
//   overflow              sticky: a write arrived while full and was dropped
//   done                  alignment captured, buffer idle in HOLD
//   rd_start              request a forward replay (honoured only in HOLD)
//   out_valid/out_ready   replay stream handshake
//   out_sym_a/_b          replayed pair
//   out_last              current pair is the final forward element
//   dbg_state             current FSM state (FILL=0 HOLD=1 PREFETCH=2 STREAM=3)
//
// Handshake: a pair transfers on every rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low the
// pair, out_last and out_valid are held unchanged. out_valid never drops
// without a transfer except on clear or reset.
module aligned_pair_buffer #(
    parameter int N       = 128,
    parameter int DEPTH   = 2 * N,
    parameter int W       = 3,
    parameter int BitAddr = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [W-1:0]       wr_sym_a,
    input  logic [W-1:0]       wr_sym_b,
    input  logic               wr_last,
    output logic [BitAddr:0]   len,
    output logic               full,
    output logic               overflow,
    output logic               done,
    input  logic               rd_start,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_sym_a,
    output logic [W-1:0]       out_sym_b,
    output logic               out_last,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_FILL     = 2'd0,
        S_HOLD     = 2'd1,
        S_PREFETCH = 2'd2,
        S_STREAM   = 2'd3
    } state_t;

    localparam logic [BitAddr:0]   LenOne = (BitAddr+1)'(1);
    localparam logic [BitAddr:0]   LenMax = (BitAddr+1)'(DEPTH);
    localparam logic [BitAddr-1:0] PtrOne = BitAddr'(1);

    state_t               r_state;
    state_t               w_next;
    logic [BitAddr-1:0]   r_wptr;
    logic [BitAddr-1:0]   r_rptr;
    logic [BitAddr:0]     r_len;
    logic                 r_full;
    logic                 r_overflow;
    logic [2*W-1:0]       r_mem [DEPTH];
    logic [2*W-1:0]       r_rdata;

    logic                 w_wr_accept;
    logic                 w_wr_drop;
    logic                 w_fire;
    logic                 w_rd_issue;
    logic [BitAddr-1:0]   w_raddr;
    logic [BitAddr:0]     w_len_m1;
    logic                 w_out_valid;
    logic                 w_out_last;
    logic                 w_done;

    assign w_wr_accept = (r_state == S_FILL) && wr_en && !r_full;
    assign w_wr_drop   = (r_state == S_FILL) && wr_en && r_full;
    assign w_fire      = w_out_valid && out_ready;
    assign w_len_m1    = r_len - LenOne;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FILL:     if (wr_last) w_next = S_HOLD;
            S_HOLD:     if (rd_start && (r_len != '0)) w_next = S_PREFETCH;
            S_PREFETCH: w_next = S_STREAM;
            S_STREAM:   if (w_fire && (r_rptr == '0)) w_next = S_HOLD;
            default:    w_next = S_FILL;
        endcase
        if (clear) w_next = S_FILL;
    end

    // ---------------- output / read-control logic ----------------
    // A read is issued either to start a replay (last stored entry) or on a
    // fire that still has entries below rptr, so the next pair lands in the
    // read register exactly when the current one is consumed.
    always_comb begin
        w_out_valid = (r_state == S_STREAM);
        w_out_last  = (r_state == S_STREAM) && (r_rptr == '0);
        w_done      = (r_state == S_HOLD);
        w_rd_issue  = 1'b0;
        w_raddr     = r_rptr;
        if (!clear) begin
            if ((r_state == S_HOLD) && rd_start && (r_len != '0)) begin
                w_rd_issue = 1'b1;
                w_raddr    = w_len_m1[BitAddr-1:0];
            end else if ((r_state == S_STREAM) && w_fire && (r_rptr != '0)) begin
                w_rd_issue = 1'b1;
                w_raddr    = r_rptr - PtrOne;
            end
        end
    end

    // ---------------- storage (contents survive reset/clear) ----------------
    always_ff @(posedge clk) begin
        if (w_wr_accept && !clear) begin
            r_mem[r_wptr] <= {wr_sym_a, wr_sym_b};
        end
    end

    // Registered read port; zeroed so the outputs show 0 after reset/clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (clear) begin
            r_rdata <= '0;
        end else if (w_rd_issue) begin
            r_rdata <= r_mem[w_raddr];
        end
    end

    // ---------------- pointers, length, flags ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_len      <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_len      <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wptr <= r_wptr + PtrOne;
                r_len  <= r_len + LenOne;
                r_full <= (r_len == (LenMax - LenOne));
            end
            if (w_wr_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_rd_issue) begin
                r_rptr <= w_raddr;
            end
        end
    end

    assign len       = r_len;
    assign full      = r_full;
    assign overflow  = r_overflow;
    assign done      = w_done;
    assign out_valid = w_out_valid;
    assign out_last  = w_out_last;
    assign out_sym_a = r_rdata[2*W-1:W];
    assign out_sym_b = r_rdata[W-1:0];
    assign dbg_state = r_state;

endmodule

// File: doc/aligned_pair_buffer.md
Name: aligned_pair_buffer

Overview:
- Buffers the aligned symbol pairs (sequence A and sequence B) produced by the Needleman-Wunsch traceback unit. Traceback emits them end-to-start.
- The block stores the pairs, tracks the alignment length, and replays the alignment in forward (start-to-end) order over a valid/ready stream.
- It sits between the traceback FSM and the output/UART formatter.
- It replaces the single-channel, write-only per-sequence aligned RAMs with one dual-channel, parametrised, flow-controlled buffer.

Parameters:
- N, 128, maximum input sequence length.
- DEPTH, 2*N, maximum alignment length (entries stored).
- W, 3, symbol width per channel (nucleotide code or gap).
- BitAddr, $clog2(DEPTH), pointer width; counters are BitAddr+1 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous restart: empties buffer, returns to FILL.
- wr_en  input  1  traceback writes one pair this cycle.
- wr_sym_a  input  W  aligned symbol, sequence A.
- wr_sym_b  input  W  aligned symbol, sequence B.
- wr_last  input  1  traceback finished (may coincide with wr_en).
- len  output  BitAddr+1  number of stored pairs.
- full  output  1  len == DEPTH.
- overflow  output  1  sticky: a write was dropped because full.
- done  output  1  alignment captured; buffer in HOLD.
- rd_start  input  1  request forward replay.
- out_valid  output  1  out_* holds a valid pair.
- out_ready  input  1  consumer accepts pair.
- out_sym_a  output  W  replayed symbol A.
- out_sym_b  output  W  replayed symbol B.
- out_last  output  1  current out pair is the alignment's first-written pair (final forward element).

Behaviour:
- Storage: DEPTH x 2W single-port-write, registered-read RAM, entry = {sym_a, sym_b}.
- Reset (rst_n low, asynchronous) and clear (synchronous) have the same effect:
  - state=FILL, wptr=0, rptr=0.
  - len=0, full=0, overflow=0, done=0.
  - out_valid=0, out_last=0, out_sym_a=0, out_sym_b=0.
  - RAM contents are not cleared.
- States: FILL, HOLD, PREFETCH, STREAM.
- FILL:
  - wr_en && !full: mem[wptr] <= pair; wptr and len increment next cycle.
  - wr_en && full: write dropped; overflow <= 1.
  - wr_last: go to HOLD. A wr_en in the same cycle is written first, so len includes it.
- HOLD:
  - done=1; wr_en and wr_last are ignored.
  - rd_start && len>0: rptr <= len-1, issue RAM read, go to PREFETCH.
  - rd_start && len==0: ignored; stay in HOLD.
- PREFETCH: one cycle for the registered RAM read. Next cycle the state is STREAM with out_valid=1. Sampled rd_start at cycle t gives out_valid at t+2.
- STREAM:
  - out_sym_a and out_sym_b show mem[rptr].
  - out_last = (rptr==0).
  - Output holds stable while out_valid && !out_ready.
  - On fire (out_valid && out_ready) with rptr>0: decrement rptr and read the next address in the same cycle, so out_valid stays high. Sustained throughput is 1 pair/cycle.
  - On fire with out_last: out_valid <= 0, go to HOLD. Contents and len are retained, so the alignment can be replayed with another rd_start.
- rd_start outside HOLD is ignored.
- clear during PREFETCH or STREAM aborts the replay: out_valid drops next cycle, and no further fire is possible.
- Reset mid-operation forces all outputs to their reset values immediately (asynchronously).
- done is de-asserted in every state except HOLD.
- full and len are registered and change only on accepted writes, clear, or reset.

Test Plan:
- Fill-and-replay: write pairs (A,B) = (0,1),(1,2),(2,3),(3,4) with wr_last on the 4th; rd_start, out_ready=1.
  - Required: len=4, done=1.
  - Replay order: (3,4),(2,3),(1,2),(0,1) on 4 consecutive cycles.
  - out_valid first at rd_start+2; out_last only on (0,1); done=1 afterwards.
- Backpressure: same data; toggle out_ready 1,0,0,1,1,0,1.
  - Required: each pair is held stable while out_ready=0.
  - Exactly 4 fires, no duplicates or skips.
- Overflow: DEPTH=8; write 10 pairs, then wr_last.
  - Required: len=8, full=1, overflow=1; replay yields the first 8 pairs in reverse.
- Empty alignment: wr_last with no writes, then rd_start.
  - Required: done=1, len=0, out_valid stays 0, state remains HOLD.
- Abort and restart: clear mid-STREAM after 2 fires, then write 3 new pairs with wr_last.
  - Required: out_valid=0 the cycle after clear; len=3; replay shows only the new pairs.
- Async reset: assert rst_n low between clock edges during STREAM.
  - Required: out_valid, done and len go to 0 without a clock edge.
  - Replay after re-fill works.
